audio_clkgen_mc: RTL and testbench
==================================

Name: audio_clkgen_mc

Overview:
- Parametrised multi-channel clock-enable and divided-clock generator in the fabric, running from the fabric clock that the MSS clock conditioning block supplies.
- Produces NCH independent outputs for the audio datapath: a one-cycle enable strobe, a 50%-duty divided clock and a per-channel lock flag.
- Divisors are runtime-programmable through a valid/ready config port. Changes are applied glitch-free at channel terminal count.
- This replaces fixed, bypass-only clock routing with programmable, lock-reported channels.

Parameters:
- NCH, 4, number of output channels (1..16)
- DIVW, 12, divisor width in bits
- LOCK_CYCLES, 4, enable strobes at a stable divisor before lock asserts (1..255)
- RST_DIV, 0, divisor loaded into every channel at reset

Ports:
- FAB_CLK  input  1  fabric clock; sole clock
- M2F_RESET_N  input  1  asynchronous active-low reset
- cfg_valid  input  1  config request
- cfg_ready  output  1  config accepted when high together with cfg_valid
- cfg_ch  input  $clog2(NCH) (min 1)  target channel
- cfg_div  input  DIVW  divisor-minus-one (N gives period N+1)
- cfg_enable  input  1  1 = run channel, 0 = stop channel
- ce_out  output  NCH  one-cycle strobe per channel
- clk_out  output  NCH  divided clock, period 2*(div+1) FAB_CLK cycles
- lock  output  NCH  channel running with a settled divisor
- all_lock  output  1  AND of lock over enabled channels; 0 if no channel is enabled
- align  input  1  synchronous restart of all channels (optional feature)

Behaviour:
- Reset is asynchronous and active-low. One clock (FAB_CLK), no other clock domains.
- Reset state of every channel:
  - disabled
  - counter = RST_DIV, active div = RST_DIV, no pending update
  - ce_out = 0, clk_out = 0, lock = 0, all_lock = 0
  - cfg_ready = 1
- Per-channel state: active div, down-counter, pending div, pending enable, pending flag, lock counter (8 bits, saturating).
- Enabled channel, counting:
  - In a cycle where counter == 0: ce_out[i] = 1 for that cycle, counter reloads active div, clk_out[i] toggles (registered, visible next cycle).
  - Otherwise the counter decrements.
  - div = 0 gives ce_out high continuously and clk_out = FAB_CLK/2.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - A write is accepted at cycle T when cfg_valid && cfg_ready.
  - cfg_ch >= NCH: the write is accepted and ignored.
- Write to a disabled channel: applied immediately. At T+1 active div = cfg_div, counter = cfg_div, clk_out = 0, lock counter cleared. If cfg_enable = 1 the channel is enabled and the first ce_out occurs at cycle T+1+cfg_div.
- Write to an enabled channel:
  - Stored as pending.
  - A divisor change is applied at the next terminal count; the reload uses the new divisor and the lock counter clears.
  - A disable is applied only at a terminal count where clk_out toggles 1->0, so the last high phase completes. clk_out then holds 0, lock clears and the pending flag clears.
  - A write with the same divisor and cfg_enable = 1 still clears lock (treated as a change).
- Lock: the lock counter increments on each ce_out of an enabled channel and saturates. lock[i] = (lock counter >= LOCK_CYCLES) && enabled.
- Simultaneous events:
  - Config accept and terminal count on the same channel in the same cycle: the terminal count reloads the old divisor; the new config becomes pending.
  - A mid-operation reset abandons all pending writes.

Optional Feature:
- Macro: AUDIO_CLKGEN_ALIGN_EN.
- With the macro defined: align = 1 at cycle T causes, for every enabled channel at T+1:
  - pending updates are applied (divisor changes and disables alike)
  - counter = active div, clk_out = 0, lock counter cleared
  - all channels become phase-aligned; cfg_ready = 1 at T+1.
- Without the macro: the align port still exists but is ignored, and no alignment logic is synthesised.

Decomposition:
- Package audio_clkgen_pkg holds:
  - the DIVW default
  - the lock counter width constant (8)
  - a channel-state struct typedef (active_div, cnt, pend_div, pend_en, pend, en, lock_cnt, clk_q)
- Sub-module audio_clkgen_ch: one channel (counter, pending logic, lock counter), instantiated NCH times by generate.
- The top level holds the config decode, the cfg_ready mux and the all_lock reduction.

Test Plan:
- Reset then enable ch0 with div = 3: ce_out[0] pulses every 4 cycles, clk_out[0] period 8, first ce_out 4 cycles after accept; lock[0] rises on the 4th strobe (LOCK_CYCLES = 4).
- While ch1 runs at div = 9, write div = 1:
  - cfg_ready low until the next terminal count
  - no ce_out spacing other than 10 or 2 cycles
  - lock[1] drops, then reasserts after 4 strobes.
- Disable ch2 (div = 5) while clk_out[2] is high: the high phase lasts the full 6 cycles, then clk_out[2] stays 0, lock[2] = 0, all_lock reflects only the remaining channels.
- div = 0 on ch3: ce_out[3] high continuously, clk_out[3] toggles every cycle; a write to cfg_ch = 7 with NCH = 4 is accepted with no state change.
- Assert M2F_RESET_N low mid-count with a pending write: all outputs go to 0 immediately (asynchronous); after release, cfg_ready = 1 and no channel runs.
- With AUDIO_CLKGEN_ALIGN_EN: channels at div = 2 and div = 5 pulse align; both first strobes land at T+3 and T+6 respectively, and clk_out edges coincide every 6 cycles.

Source files
------------

// File: rtl/audio_clkgen_pkg.sv
// audio_clkgen shared types and constants.
// Channel state bundle, divisor width default and lock counter width.
package audio_clkgen_pkg;

    localparam int DIVW_DEF = 12;
    localparam int LOCK_W = 8;

    typedef struct packed {
        logic [DIVW_DEF-1:0] active_div;
        logic [DIVW_DEF-1:0] cnt;
        logic [DIVW_DEF-1:0] pend_div;
        logic                pend_en;
        logic                pend;
        logic                en;
        logic [LOCK_W-1:0]   lock_cnt;
        logic                clk_q;
    } ch_state_t;

endpackage

// File: rtl/audio_clkgen_ch.sv
// One audio clock channel: down-counter, pending update, lock counter.
// Optional phase-align restart when AUDIO_CLKGEN_ALIGN_EN is defined.
module audio_clkgen_ch
    import audio_clkgen_pkg::*;
#(
    parameter int LOCK_CYCLES = 4,
    parameter int RST_DIV = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [DIVW_DEF-1:0] wr_div,
    input  logic                wr_en,
    input  logic                align,
    output logic                ce,
    output logic                clk_out,
    output logic                lock,
    output logic                en,
    output logic                pend
);

    localparam logic [DIVW_DEF-1:0] RST_D = DIVW_DEF'(RST_DIV);
    localparam logic [LOCK_W-1:0] LOCK_TH = LOCK_W'(LOCK_CYCLES);
    localparam ch_state_t RST_STATE = '{
        active_div: RST_D,
        cnt:        RST_D,
        pend_div:   '0,
        pend_en:    1'b0,
        pend:       1'b0,
        en:         1'b0,
        lock_cnt:   '0,
        clk_q:      1'b0
    };

    ch_state_t st;
    ch_state_t st_nx;
    logic      tc;

    assign tc      = st.en && (st.cnt == '0);
    assign ce      = tc;
    assign clk_out = st.clk_q;
    assign lock    = st.en && (st.lock_cnt >= LOCK_TH);
    assign en      = st.en;
    assign pend    = st.pend;

`ifdef AUDIO_CLKGEN_ALIGN_EN
    logic [DIVW_DEF-1:0] al_div;
    logic                al_en;

    // Divisor/enable a restart lands on: fresh write, else pending, else current.
    always_comb begin
        al_div = st.active_div;
        al_en  = 1'b1;
        if (wr) begin
            al_div = wr_div;
            al_en  = wr_en;
        end else if (st.pend) begin
            al_div = st.pend_div;
            al_en  = st.pend_en;
        end
    end
`else
    logic align_unused;
    assign align_unused = align;
`endif

    // Next channel state: restart, immediate write, terminal count, countdown.
    always_comb begin
        st_nx = st;
`ifdef AUDIO_CLKGEN_ALIGN_EN
        if (align && st.en) begin
            st_nx.active_div = al_div;
            st_nx.cnt        = al_div;
            st_nx.en         = al_en;
            st_nx.clk_q      = 1'b0;
            st_nx.lock_cnt   = '0;
            st_nx.pend       = 1'b0;
        end else
`endif
        if (wr && !st.en) begin
            st_nx.active_div = wr_div;
            st_nx.cnt        = wr_div;
            st_nx.en         = wr_en;
            st_nx.clk_q      = 1'b0;
            st_nx.lock_cnt   = '0;
        end else begin
            if (tc) begin
                st_nx.cnt   = st.active_div;
                st_nx.clk_q = ~st.clk_q;
                if (st.lock_cnt != '1) begin
                    st_nx.lock_cnt = st.lock_cnt + LOCK_W'(1);
                end
                if (st.pend && st.pend_en) begin
                    st_nx.active_div = st.pend_div;
                    st_nx.cnt        = st.pend_div;
                    st_nx.lock_cnt   = '0;
                    st_nx.pend       = 1'b0;
                end else if (st.pend && st.clk_q) begin
                    st_nx.en       = 1'b0;
                    st_nx.clk_q    = 1'b0;
                    st_nx.lock_cnt = '0;
                    st_nx.pend     = 1'b0;
                end
            end else if (st.en) begin
                st_nx.cnt = st.cnt - DIVW_DEF'(1);
            end
            if (wr) begin
                st_nx.pend     = 1'b1;
                st_nx.pend_div = wr_div;
                st_nx.pend_en  = wr_en;
            end
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= RST_STATE;
        end else begin
            st <= st_nx;
        end
    end

endmodule

// File: rtl/audio_clkgen_mc.sv
// Multi-channel audio clock-enable / divided-clock generator.
// Define AUDIO_CLKGEN_ALIGN_EN to enable the align restart input.
module audio_clkgen_mc
    import audio_clkgen_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DIVW = DIVW_DEF,
    parameter int LOCK_CYCLES = 4,
    parameter int RST_DIV = 0
) (
    input  logic                                 FAB_CLK,
    input  logic                                 M2F_RESET_N,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] cfg_ch,
    input  logic [DIVW-1:0]                      cfg_div,
    input  logic                                 cfg_enable,
    output logic [NCH-1:0]                       ce_out,
    output logic [NCH-1:0]                       clk_out,
    output logic [NCH-1:0]                       lock,
    output logic                                 all_lock,
    input  logic                                 align
);

    logic [NCH-1:0] wr;
    logic [NCH-1:0] en;
    logic [NCH-1:0] pend;

    // Ready mux and write decode; out-of-range channels accept and drop.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(cfg_ch) == i) begin
                cfg_ready = !pend[i];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            wr[i] = cfg_valid && cfg_ready && (int'(cfg_ch) == i);
        end
    end

    assign all_lock = (|en) && (&(lock | ~en));

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        audio_clkgen_ch #(
            .LOCK_CYCLES(LOCK_CYCLES),
            .RST_DIV(RST_DIV)
        ) u_ch (
            .clk(FAB_CLK),
            .rst_n(M2F_RESET_N),
            .wr(wr[g]),
            .wr_div(cfg_div),
            .wr_en(cfg_enable),
            .align(align),
            .ce(ce_out[g]),
            .clk_out(clk_out[g]),
            .lock(lock[g]),
            .en(en[g]),
            .pend(pend[g])
        );
    end

endmodule

// File: tb/tb_audio_clkgen_mc.sv
// Scoreboard bench for audio_clkgen_mc with an event-time channel model.
// Honours AUDIO_CLKGEN_ALIGN_EN the same way as the design.
module tb_audio_clkgen_mc;

    localparam int NCH = 6;
    localparam int LOCKC = 4;
`ifdef AUDIO_CLKGEN_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    typedef struct {
        logic [NCH-1:0] ce;
        logic [NCH-1:0] ck;
        logic [NCH-1:0] lk;
        logic           al;
        logic           rdy;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_ch;
    logic [11:0]    cfg_div;
    logic           cfg_enable;
    logic [NCH-1:0] ce_out;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] lock;
    logic           all_lock;
    logic           align;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // model: strobe times are absolute cycle numbers
    int cyc_n = 0;
    bit m_en[NCH];
    bit m_clk[NCH];
    bit m_pend[NCH];
    bit m_pen[NCH];
    int m_div[NCH];
    int m_pdiv[NCH];
    int m_next[NCH];
    int m_str[NCH];

    audio_clkgen_mc #(
        .NCH(NCH),
        .DIVW(12),
        .LOCK_CYCLES(LOCKC),
        .RST_DIV(0)
    ) dut (
        .FAB_CLK(clk),
        .M2F_RESET_N(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_enable(cfg_enable),
        .ce_out(ce_out),
        .clk_out(clk_out),
        .lock(lock),
        .all_lock(all_lock),
        .align(align)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0;
            m_clk[i] = 0;
            m_pend[i] = 0;
            m_pen[i] = 0;
            m_div[i] = 0;
            m_pdiv[i] = 0;
            m_next[i] = 0;
            m_str[i] = 0;
        end
    endtask

    function automatic exp_t expect_now(input int ch);
        exp_t e;
        bit any_en;
        bit all_lk;
        any_en = 0;
        all_lk = 1;
        for (int i = 0; i < NCH; i++) begin
            e.ce[i] = m_en[i] && (m_next[i] == cyc_n);
            e.ck[i] = m_clk[i];
            e.lk[i] = m_en[i] && (m_str[i] >= LOCKC);
            if (m_en[i]) begin
                any_en = 1;
                if (!e.lk[i]) all_lk = 0;
            end
        end
        e.al = any_en && all_lk;
        e.rdy = (ch >= NCH) ? 1'b1 : !m_pend[ch];
        return e;
    endfunction

    task automatic advance(input bit acc, input int ch, input int d,
                           input bit e, input bit al);
        for (int i = 0; i < NCH; i++) begin
            bit hit;
            bit s;
            hit = acc && (ch == i);
            s = m_en[i] && (m_next[i] == cyc_n);
            if (ALIGN_ON && al && m_en[i]) begin
                if (hit) begin
                    m_div[i] = d;
                    m_en[i] = e;
                end else if (m_pend[i]) begin
                    m_div[i] = m_pdiv[i];
                    m_en[i] = m_pen[i];
                end
                m_next[i] = cyc_n + 1 + m_div[i];
                m_clk[i] = 0;
                m_str[i] = 0;
                m_pend[i] = 0;
            end else if (hit && !m_en[i]) begin
                m_div[i] = d;
                m_en[i] = e;
                m_next[i] = cyc_n + 1 + d;
                m_clk[i] = 0;
                m_str[i] = 0;
            end else begin
                if (s) begin
                    if (m_pend[i] && !m_pen[i] && m_clk[i]) begin
                        m_en[i] = 0;
                        m_clk[i] = 0;
                        m_str[i] = 0;
                        m_pend[i] = 0;
                    end else begin
                        m_clk[i] = !m_clk[i];
                        m_str[i] = (m_str[i] < 255) ? m_str[i] + 1 : 255;
                        m_next[i] = cyc_n + 1 + m_div[i];
                        if (m_pend[i] && m_pen[i]) begin
                            m_div[i] = m_pdiv[i];
                            m_next[i] = cyc_n + 1 + m_pdiv[i];
                            m_str[i] = 0;
                            m_pend[i] = 0;
                        end
                    end
                end
                if (hit) begin
                    m_pend[i] = 1;
                    m_pdiv[i] = d;
                    m_pen[i] = e;
                end
            end
        end
        cyc_n++;
    endtask

    task automatic cyc(input bit v, input int ch, input int d,
                       input bit e, input bit al, output bit acc);
        exp_t x;
        @(posedge clk);
        #1;
        cfg_valid = v;
        cfg_ch = 3'(ch);
        cfg_div = 12'(d);
        cfg_enable = e;
        align = al;
        x = expect_now(ch);
        sb.push_back(x);
        acc = v && x.rdy;
        advance(acc, ch, d, e, al);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cyc(0, 0, 0, 0, 0, acc);
    endtask

    task automatic wr_cfg(input int ch, input int d, input bit e);
        bit acc;
        int n;
        n = 0;
        acc = 0;
        while (!acc && n < 300) begin
            cyc(1, ch, d, e, 0, acc);
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL wr_cfg_timeout ch%0d: accepted 0 required 1", ch);
        end
    endtask

    task automatic do_reset(input int n);
        exp_t x;
        @(posedge clk);
        #1;
        cfg_valid = 0;
        align = 0;
        #1;
        rst_n = 0;
        model_reset();
        x = expect_now(0);
        sb.push_back(x);
        repeat (n - 1) begin
            @(posedge clk);
            #1;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic chk(input string nm, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t: actual %b required %b", nm, $time, act, req);
        end
    endtask

    // monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("ce_out", ce_out, x.ce);
            chk("clk_out", clk_out, x.ck);
            chk("lock", lock, x.lk);
            chk("all_lock", NCH'(all_lock), NCH'(x.al));
            chk("cfg_ready", NCH'(cfg_ready), NCH'(x.rdy));
        end
    end

    initial begin
        bit acc;
        rst_n = 0;
        cfg_valid = 0;
        cfg_ch = 0;
        cfg_div = 0;
        cfg_enable = 0;
        align = 0;
        model_reset();
        do_reset(3);
        idle(3);
        wr_cfg(0, 3, 1);
        idle(20);
        wr_cfg(1, 9, 1);
        idle(45);
        wr_cfg(1, 1, 1);
        wr_cfg(1, 1, 1);
        idle(20);
        wr_cfg(2, 5, 1);
        idle(8);
        wr_cfg(2, 0, 0);
        idle(30);
        wr_cfg(3, 0, 1);
        idle(10);
        wr_cfg(7, 5, 1);
        wr_cfg(6, 2, 1);
        idle(10);
        wr_cfg(4, 2, 1);
        wr_cfg(5, 5, 1);
        idle(7);
        cyc(0, 0, 0, 0, 1, acc);
        idle(25);
        for (int i = 0; i < 2500; i++) begin
            int ch;
            int d;
            if (i == 1200) begin
                wr_cfg(0, 30, 1);
                wr_cfg(0, 7, 1);
                idle(3);
                do_reset(4);
                idle(5);
            end
            ch = int'($urandom_range(0, 7));
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                            : int'($urandom_range(0, 7));
            cyc($urandom_range(0, 5) == 0, ch, d,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 59) == 0, acc);
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
